// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch stage: NOP encoding and the
// fetch-queue entry layout.
package if_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // PC width carried by a queue entry; the top-level XLEN must equal this.
  localparam int unsigned FQ_XLEN = 32;

  typedef struct packed {
    logic [31:0]        instr;
    logic [FQ_XLEN-1:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/if_fetch_queue.sv
// Synchronous FIFO holding fetched {instr, pc} entries between IMEM and ID.
// clear discards everything and wins over push and pop in the same cycle.
module if_fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             do_pop;

  assign empty  = (count == '0);
  assign full   = (count == (PW+1)'(DEPTH));
  assign do_pop = pop && !empty;
  assign head   = mem[rptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)   wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; count and the
  // pointers alone decide which slots hold live data.
  always_ff @(posedge clk) begin
    if (!rst && !clear && push) mem[wptr] <= din;
  end

  // The credit scheme upstream guarantees a reserved slot for every push.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst || clear)
    push |-> !full);

endmodule

// File: rtl/if_stage_fq.sv
// Instruction fetch stage: PC register, synchronous-read IMEM, credit-based
// issue into a fetch queue, and a valid/ready handoff to ID with redirect flush.
module if_stage_fq
  import if_pkg::*;
#(
  parameter int              XLEN       = FQ_XLEN,
  parameter int              IMEM_DEPTH = 1024,
  parameter int              FQ_DEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      redirect,
  input  logic [XLEN-1:0]           redirect_target,
  input  logic                      id_ready,
  output logic                      id_valid,
  output logic [31:0]               id_instr,
  output logic [XLEN-1:0]           id_pc,
  output logic [XLEN-1:0]           id_pc_plus4,
  output logic [$clog2(FQ_DEPTH):0] fq_count
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [31:0]     imem [IMEM_DEPTH];
  logic [31:0]     imem_rdata;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_inflight;
  logic            inflight;
  logic            issue;
  logic            push;
  logic            pop;
  logic            fq_full;
  logic            fq_empty;
  logic [CW:0]     credit_used;
  fq_entry_t       push_entry;
  fq_entry_t       head;

  // A redirect voids both the returning response and any pop handshake.
  assign pop  = id_valid && id_ready && !redirect;
  assign push = inflight && !redirect;

  // Slots committed after this edge: occupied + in flight, minus the one popped now.
  assign credit_used = (CW+1)'(fq_count) + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue       = !rst && !redirect && (credit_used < (CW+1)'(FQ_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      pc_inflight <= '0;
      inflight    <= 1'b0;
    end else if (redirect) begin
      pc       <= redirect_target & ~XLEN'(3);
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc          <= pc + XLEN'(4);
        pc_inflight <= pc;
      end
    end
  end

  // Upper PC bits are not decoded, so the fetch address wraps within IMEM.
  always_ff @(posedge clk) begin
    if (issue) imem_rdata <= imem[pc[AW+1:2]];
  end

  assign push_entry.instr = imem_rdata;
  assign push_entry.pc    = pc_inflight;

  if_fetch_queue #(
    .WIDTH ($bits(fq_entry_t)),
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .head  (head),
    .count (fq_count),
    .full  (fq_full),
    .empty (fq_empty)
  );

  assign id_valid = !fq_empty;

  // NOTE: every output gets a default before the conditional override so
  // always_comb never infers a latch.
  always_comb begin
    id_instr    = NOP_INSTR;
    id_pc       = '0;
    id_pc_plus4 = '0;
    if (id_valid) begin
      id_instr    = head.instr;
      id_pc       = head.pc;
      id_pc_plus4 = head.pc + XLEN'(4);
    end
  end

  // A full queue leaves no credit, so nothing can be in flight alongside it.
  a_full_no_inflight : assert property (@(posedge clk) disable iff (rst)
    fq_full |-> !inflight);

endmodule

// File: tb/tb_if_stage_fq.sv
// Directed bench for if_stage_fq: stimulus pushes the expected fetch stream
// into a scoreboard; a monitor pops and compares on every ID handshake.
module tb_if_stage_fq;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [2:0]  fq_count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  if_stage_fq dut (
    .clk             (clk),
    .rst             (rst),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .id_ready        (id_ready),
    .id_valid        (id_valid),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_pc_plus4     (id_pc_plus4),
    .fq_count        (fq_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // IMEM is preloaded with 0x1000_0000 + word index; 1024 words.
  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return 32'h1000_0000 + ((pc >> 2) & 32'h0000_03FF);
  endfunction

  task automatic push_stream(input logic [31:0] start, input int n);
    logic [31:0] p;
    exp_t        e;
    p = start & 32'hFFFF_FFFC;
    for (int i = 0; i < n; i++) begin
      e.pc    = p;
      e.instr = mem_word(p);
      e.pc4   = p + 32'd4;
      sb.push_back(e);
      p = p + 32'd4;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Monitor: every accepted head must be the next entry of the expected stream.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && !redirect && id_valid && id_ready) begin
      if (sb.size() == 0) begin
        check("pop_unexpected", id_pc, 32'hDEAD_BEEF);
      end else begin
        e = sb.pop_front();
        check("pop_pc", id_pc, e.pc);
        check("pop_instr", id_instr, e.instr);
        check("pop_pc_plus4", id_pc_plus4, e.pc4);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_target = '0; id_ready = 1'b0;
    for (int i = 0; i < 1024; i++) dut.imem[i] = 32'h1000_0000 + 32'(i);
    cyc(); cyc();
    smp();
    check("rst_valid", {31'b0, id_valid}, 32'd0);
    check("rst_instr", id_instr, 32'h0000_0013);
    check("rst_pc", id_pc, 32'd0);
    check("rst_pc_plus4", id_pc_plus4, 32'd0);
    check("rst_count", {29'b0, fq_count}, 32'd0);

    // Streaming from RESET_PC: valid appears two cycles after reset release.
    cyc(); rst = 1'b0; id_ready = 1'b1; sb.delete(); push_stream(32'h0, 64);
    smp(); check("stream_valid_c0", {31'b0, id_valid}, 32'd0);
    cyc(); smp(); check("stream_valid_c1", {31'b0, id_valid}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      cyc(); smp(); check("stream_valid", {31'b0, id_valid}, 32'd1);
    end

    // Backpressure: queue saturates at 4 with head pc 24 waiting.
    cyc(); id_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cyc();
      smp();
      if (i >= 3) check("bp_count", {29'b0, fq_count}, 32'd4);
    end
    check("bp_head_pc", id_pc, 32'd24);
    cyc(); id_ready = 1'b1; smp();
    for (int i = 0; i < 4; i++) begin cyc(); smp(); end

    // Refill, pop once (queue 3 + one in flight), then redirect to 0x103.
    cyc(); id_ready = 1'b0; smp();
    for (int i = 0; i < 3; i++) begin cyc(); smp(); end
    check("refill_count", {29'b0, fq_count}, 32'd4);
    cyc(); id_ready = 1'b1; smp();
    cyc(); id_ready = 1'b0; redirect = 1'b1; redirect_target = 32'h0000_0103;
    sb.delete(); push_stream(32'h100, 64);
    smp(); check("rd_pre_count", {29'b0, fq_count}, 32'd3);
    cyc(); redirect = 1'b0;
    smp(); check("rd_r1_count", {29'b0, fq_count}, 32'd0);
    check("rd_r1_valid", {31'b0, id_valid}, 32'd0);
    cyc(); smp(); check("rd_r2_valid", {31'b0, id_valid}, 32'd0);
    cyc(); smp(); check("rd_r3_valid", {31'b0, id_valid}, 32'd1);
    check("rd_r3_pc", id_pc, 32'h0000_0100);
    check("rd_r3_instr", id_instr, 32'h1000_0040);
    cyc(); id_ready = 1'b1; smp();
    for (int i = 0; i < 4; i++) begin cyc(); smp(); end

    // Redirect with a live pop, then back-to-back redirects: 0x80 wins.
    cyc(); redirect = 1'b1; redirect_target = 32'h0000_0040; sb.delete();
    smp(); check("rd2_pop_valid", {31'b0, id_valid}, 32'd1);
    cyc(); redirect_target = 32'h0000_0080; sb.delete(); push_stream(32'h80, 64);
    smp();
    cyc(); redirect = 1'b0; smp(); check("rd2_r1_valid", {31'b0, id_valid}, 32'd0);
    cyc(); smp(); check("rd2_r2_valid", {31'b0, id_valid}, 32'd0);
    cyc(); smp(); check("rd2_r3_valid", {31'b0, id_valid}, 32'd1);
    check("rd2_r3_pc", id_pc, 32'h0000_0080);
    check("rd2_r3_instr", id_instr, 32'h1000_0020);
    for (int i = 0; i < 5; i++) begin cyc(); smp(); end

    // IMEM index wrap at 0xFFC -> 0x1000.
    cyc(); redirect = 1'b1; redirect_target = 32'h0000_0FFC; sb.delete();
    push_stream(32'h0000_0FFC, 64);
    smp();
    cyc(); redirect = 1'b0; smp();
    cyc(); smp();
    cyc(); smp(); check("wrap_pc", id_pc, 32'h0000_0FFC);
    check("wrap_instr", id_instr, 32'h1000_03FF);
    cyc(); smp(); check("wrap2_pc", id_pc, 32'h0000_1000);
    check("wrap2_instr", id_instr, 32'h1000_0000);
    check("wrap2_pc_plus4", id_pc_plus4, 32'h0000_1004);
    for (int i = 0; i < 3; i++) begin cyc(); smp(); end

    // PC wrap modulo 2^32; low target bits ignored.
    cyc(); redirect = 1'b1; redirect_target = 32'hFFFF_FFFE; sb.delete();
    push_stream(32'hFFFF_FFFC, 64);
    smp();
    cyc(); redirect = 1'b0; smp();
    cyc(); smp();
    cyc(); smp(); check("pcwrap_pc", id_pc, 32'hFFFF_FFFC);
    check("pcwrap_pc_plus4", id_pc_plus4, 32'h0000_0000);
    check("pcwrap_instr", id_instr, 32'h1000_03FF);
    cyc(); smp(); check("pcwrap2_pc", id_pc, 32'h0000_0000);
    check("pcwrap2_instr", id_instr, 32'h1000_0000);
    for (int i = 0; i < 3; i++) begin cyc(); smp(); end

    // Reset mid-stream with 3 queued entries and one read in flight.
    cyc(); id_ready = 1'b0; smp();
    for (int i = 0; i < 4; i++) begin cyc(); smp(); end
    check("mrst_fill_count", {29'b0, fq_count}, 32'd4);
    cyc(); id_ready = 1'b1; smp();
    cyc(); rst = 1'b1; id_ready = 1'b0;
    smp(); check("mrst_pre_count", {29'b0, fq_count}, 32'd3);
    cyc(); rst = 1'b0; id_ready = 1'b1; sb.delete(); push_stream(32'h0, 64);
    smp(); check("mrst_valid", {31'b0, id_valid}, 32'd0);
    check("mrst_count", {29'b0, fq_count}, 32'd0);
    check("mrst_instr", id_instr, 32'h0000_0013);
    check("mrst_pc", id_pc, 32'd0);
    cyc(); smp(); check("mrst_c1_valid", {31'b0, id_valid}, 32'd0);
    cyc(); smp(); check("mrst_c2_valid", {31'b0, id_valid}, 32'd1);
    check("mrst_c2_pc", id_pc, 32'd0);
    check("mrst_c2_instr", id_instr, 32'h1000_0000);
    for (int i = 0; i < 4; i++) begin cyc(); smp(); end

    cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
